// File: rtl/fisc_mem_arbiter_if.sv
// Request/response bundle between the fetch port, the load/store port and the
// single memory channel of fisc_mem_arbiter.
//   slave  : arbiter side (consumes requests, drives acks/rdata and memory strobes)
//   master : environment side (requesters plus memory model)
interface fisc_mem_arbiter_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 16
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // load/store port
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_ack;
    // memory channel
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_din;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_din,
        output if_rdata, if_ack, ls_rdata, ls_ack,
        output mem_rd, mem_wr, mem_addr, mem_dout
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_din,
        input  if_rdata, if_ack, ls_rdata, ls_ack,
        input  mem_rd, mem_wr, mem_addr, mem_dout
    );
endinterface

// File: rtl/fisc_mem_arbiter.sv
// Two-requester memory arbiter: fetch (read-only) and load/store share one
// memory channel. Ties alternate on a last-grant flop; reads hold mem_rd for
// RD_LAT cycles and capture mem_din on the final edge; each transaction ends
// with a one-cycle ack to the granted requester. All outputs are registered.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   wait_n   : 0 blocks new grants (in-flight transaction unaffected)
//   busy     : 1 whenever the FSM is not IDLE
//   bus      : requester/memory bundle (slave modport)
module fisc_mem_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1      // legal 1..15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wait_n,
    output logic                  busy,
    fisc_mem_arbiter_if.slave     bus
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                gnt_ls_q,   gnt_ls_d;    // granted requester: 1 = load/store
    logic                last_ls_q,  last_ls_d;   // last grant: 0 = fetch
    logic                mem_rd_q,   mem_rd_d;
    logic                mem_wr_q,   mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_dout_q, mem_dout_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                if_ack_q,   if_ack_d;
    logic                ls_ack_q,   ls_ack_d;
    logic                busy_q,     busy_d;
    logic                pick_ls;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_ls_d   = gnt_ls_q;
        last_ls_d  = last_ls_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        pick_ls    = 1'b0;

        case (state_q)
            IDLE: begin
                if (wait_n && (bus.if_req || bus.ls_req)) begin
                    // On a tie, load/store wins unless it was granted last
                    pick_ls    = bus.ls_req && (!bus.if_req || !last_ls_q);
                    gnt_ls_d   = pick_ls;
                    last_ls_d  = pick_ls;
                    mem_addr_d = pick_ls ? bus.ls_addr : bus.if_addr;
                    if (pick_ls && bus.ls_we) begin
                        state_d    = WRITE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = bus.ls_wdata;
                    end else begin
                        state_d  = READ;
                        mem_rd_d = 1'b1;
                        cnt_d    = CNT_W'(RD_LAT);
                    end
                end
            end
            READ: begin
                // cnt_q counts the mem_rd cycles still to run including this one
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                    if (gnt_ls_q) ls_rdata_d = bus.mem_din;
                    else          if_rdata_d = bus.mem_din;
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_rd_d = 1'b1;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                // Ack register lands as the FSM returns to IDLE, so the acked
                // requester has that IDLE cycle to drop its request
                if_ack_d = !gnt_ls_q;
                ls_ack_d = gnt_ls_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_ls_q   <= 1'b0;
            last_ls_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_ls_q   <= gnt_ls_d;
            last_ls_q  <= last_ls_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_ack_q   <= if_ack_d;
            ls_ack_q   <= ls_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.ls_ack   = ls_ack_q;

endmodule

// File: doc/fisc_mem_arbiter.md
FISC_MEM_ARBITER -- requirements
Module: fisc_mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, memory word / integer width.
REQ-002 Parameter ADDR_W, default 16, memory word-address width.
REQ-003 Parameter RD_LAT, default 1 (legal 1..15), cycles from mem_rd first high to mem_din valid.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset_n  input  1  reset is asynchronous and active-low.
REQ-006 wait_n  input  1  0 = block new grants; a transaction already in flight completes.
REQ-007 if_req  input  1  fetch read request, held until if_ack.
REQ-008 if_addr  input  ADDR_W  fetch word address.
REQ-009 if_rdata  output  DATA_W  fetch read data, valid while if_ack=1.
REQ-010 if_ack  output  1  one-cycle fetch completion pulse.
REQ-011 ls_req  input  1  load/store request, held until ls_ack.
REQ-012 ls_we  input  1  1 = write, 0 = read.
REQ-013 ls_addr  input  ADDR_W  load/store word address.
REQ-014 ls_wdata  input  DATA_W  store data.
REQ-015 ls_rdata  output  DATA_W  load data, valid while ls_ack=1.
REQ-016 ls_ack  output  1  one-cycle load/store completion pulse.
REQ-017 mem_rd  output  1  active-high read strobe to memory channel.
REQ-018 mem_wr  output  1  active-high write strobe to memory channel.
REQ-019 mem_addr  output  ADDR_W  memory address.
REQ-020 mem_dout  output  DATA_W  memory write data.
REQ-021 mem_din  input  DATA_W  memory read data.
REQ-022 busy  output  1  1 whenever state is not IDLE.

Function
REQ-023 All outputs registered; FSM states IDLE, READ, WRITE, RESP.
REQ-024 Requests sampled only in IDLE with wait_n=1; in any other state or with wait_n=0, requests are ignored and FSM holds IDLE.
REQ-025 Arbitration: one requester -> grant it; both -> grant the one not granted last (last_grant flop, reset value = fetch, so ls wins first tie).
REQ-026 Grant latches addr, we, wdata and granted ID; later changes to requester inputs do not affect the transaction.
REQ-027 Read grant: next cycle mem_rd=1, mem_addr=latched addr; mem_rd held exactly RD_LAT cycles via 4-bit down-counter.
REQ-028 On the edge ending the last mem_rd cycle, mem_din captured into the granted requester's rdata; mem_rd drops; FSM -> RESP.
REQ-029 Write grant (ls_we=1): next cycle mem_wr=1 for exactly one cycle with mem_addr, mem_dout; then FSM -> RESP.
REQ-030 RESP: granted ack=1 for exactly one cycle, then IDLE; the other ack stays 0.
REQ-031 Latency, request sampled at edge E0: read ack high in cycle starting at E0+RD_LAT+1; write ack high in cycle starting at E0+2.
REQ-032 mem_rd and mem_wr never high together; never high in IDLE or RESP.
REQ-033 if_rdata/ls_rdata hold last captured value until next capture for that port.
REQ-034 Requester dropping req mid-transaction: transaction still completes, ack still pulsed.
REQ-035 Minimum spacing between grants: 1 IDLE cycle after RESP; an acked requester's req is not resampled in RESP.
REQ-036 wait_n low during READ/WRITE/RESP: no effect on in-flight transaction.

Reset
REQ-037 reset_n=0 asynchronously forces IDLE; mem_rd=0, mem_wr=0, if_ack=0, ls_ack=0, busy=0; mem_addr, mem_dout, if_rdata, ls_rdata = 0; counter=0; last_grant=fetch.
REQ-038 Reset mid-transaction aborts it with no ack; first grant after release follows REQ-025.

Verification
REQ-039 RD_LAT=1, if_req=1, if_addr=0x0010, mem_din=0xDEADBEEF00000001 -> mem_rd high 1 cycle at addr 0x0010; if_ack at E0+2 with if_rdata=0xDEADBEEF00000001.
REQ-040 ls_req=1, ls_we=1, ls_addr=0x0020, ls_wdata=0x55 -> mem_wr high exactly 1 cycle with addr 0x0020, dout 0x55; ls_ack at E0+2; mem_rd stays 0.
REQ-041 if_req and ls_req held high together out of reset -> grant order ls, if, ls, if; each ack single-cycle, never simultaneous.
REQ-042 RD_LAT=3, if_req with wait_n dropped to 0 during READ -> mem_rd high 3 cycles, if_ack still at E0+4; no new grant until wait_n=1.
REQ-043 reset_n pulsed low during READ cycle 2 -> mem_rd and busy drop immediately, no ack; after release, ls_req granted normally.
REQ-044 Requester drops req one cycle after grant -> transaction completes, ack pulsed once; no second grant.
